// File: rtl/axis_sort_feeder_pkg.sv
// Shared definitions for the sort-engine input stream: element width,
// feeder state encoding and the transfer-length validity rule.
package axis_sort_pkg;

    localparam int unsigned ELEM_W = 16;

    typedef enum logic {
        IDLE,
        SEND
    } feeder_state_t;

    // A transfer must carry whole beats (even, nonzero) and fit the buffer.
    function automatic bit length_ok(input int unsigned len, input int unsigned depth);
        return (len != 0) && !len[0] && (len <= depth);
    endfunction

endpackage

// File: rtl/axis_sort_feeder_if.sv
// AXI-Stream bundle between the feeder (master) and the sort engine (slave).
interface axis_sort_feeder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_sort_feeder_buf.sv
// Element buffer: one element-wide write port, one paired read port that
// returns elements 2k and 2k+1 for beat address k. Contents are not reset.
module axis_sort_feeder_buf
    import axis_sort_pkg::*;
#(
    parameter  int ELEM_WIDTH = ELEM_W,
    parameter  int ARRAY_SIZE = 1024,
    localparam int AW         = $clog2(ARRAY_SIZE),
    localparam int PAIRS      = ARRAY_SIZE / 2,
    localparam int BW         = (PAIRS > 1) ? $clog2(PAIRS) : 1
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [ELEM_WIDTH-1:0] i_wr_data,
    input  logic [BW-1:0]         i_rd_beat,
    output logic [ELEM_WIDTH-1:0] o_rd_lo,
    output logic [ELEM_WIDTH-1:0] o_rd_hi
);

    // Even and odd elements live in separate banks so a beat is one lookup.
    logic [ELEM_WIDTH-1:0] r_lo [PAIRS];
    logic [ELEM_WIDTH-1:0] r_hi [PAIRS];
    logic [BW-1:0]         w_wr_pair;

    assign w_wr_pair = BW'(i_wr_addr >> 1);

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            if (i_wr_addr[0]) r_hi[w_wr_pair] <= i_wr_data;
            else              r_lo[w_wr_pair] <= i_wr_data;
        end
    end

    assign o_rd_lo = r_lo[i_rd_beat];
    assign o_rd_hi = r_hi[i_rd_beat];

endmodule

// File: rtl/axis_sort_feeder.sv
// AXI-Stream producer feeding the sort engine: streams a locally buffered
// array of elements, two per beat, and drives the latched sort direction.
module axis_sort_feeder
    import axis_sort_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ELEM_WIDTH = ELEM_W,
    parameter  int ARRAY_SIZE = 1024,
    localparam int AW         = $clog2(ARRAY_SIZE),
    localparam int LW         = AW + 1,
    localparam int PAIRS      = ARRAY_SIZE / 2,
    localparam int BW         = (PAIRS > 1) ? $clog2(PAIRS) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [ELEM_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [LW-1:0]         length,
    input  logic                  dir_in,
    output logic                  sort_dir,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    axis_sort_feeder_if.master    m
);

    feeder_state_t         r_state, w_next;
    logic [AW-1:0]         r_beat_idx;
    logic [AW-1:0]         r_last_idx;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tlast;
    logic                  r_sort_dir;
    logic                  r_done;
    logic                  r_err;

    logic                  w_accept, w_reject, w_adv, w_final, w_is_last;
    logic [BW-1:0]         w_rd_beat;
    logic [ELEM_WIDTH-1:0] w_rd_lo, w_rd_hi, w_lo0, w_hi0;

    assign w_is_last = (r_beat_idx == r_last_idx);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        w_adv    = 1'b0;
        w_final  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (length_ok(32'(length), ARRAY_SIZE)) begin
                        w_accept = 1'b1;
                        w_next   = SEND;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            SEND: begin
                if (m.tready) begin
                    if (w_is_last) begin
                        w_final = 1'b1;
                        w_next  = IDLE;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // In SEND the read port looks one beat ahead so the next beat loads on
    // the handshake edge; in IDLE it presents beat 0 for the start edge.
    assign w_rd_beat = (r_state == SEND) ? BW'(r_beat_idx + 1'b1) : '0;

    // A write landing on the start edge has not reached the array yet, so
    // forward it into beat 0 directly.
    assign w_lo0 = (wr_en && wr_addr == AW'(0)) ? wr_data : w_rd_lo;
    assign w_hi0 = (wr_en && wr_addr == AW'(1)) ? wr_data : w_rd_hi;

    axis_sort_feeder_buf #(
        .ELEM_WIDTH (ELEM_WIDTH),
        .ARRAY_SIZE (ARRAY_SIZE)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (wr_en && (r_state == IDLE)),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_beat (w_rd_beat),
        .o_rd_lo   (w_rd_lo),
        .o_rd_hi   (w_rd_hi)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_beat_idx <= '0;
            r_last_idx <= '0;
            r_tdata    <= '0;
            r_tlast    <= 1'b0;
            r_sort_dir <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_final;
            r_err  <= w_reject;
            if (w_accept) begin
                r_beat_idx <= '0;
                r_last_idx <= AW'((length >> 1) - 1'b1);
                r_sort_dir <= dir_in;
                r_tdata    <= DATA_WIDTH'({w_hi0, w_lo0});
                r_tlast    <= (length == LW'(2));
            end else if (w_adv) begin
                r_beat_idx <= r_beat_idx + 1'b1;
                r_tdata    <= DATA_WIDTH'({w_rd_hi, w_rd_lo});
                r_tlast    <= ((r_beat_idx + 1'b1) == r_last_idx);
            end else if (w_final) begin
                r_tlast <= 1'b0;
            end
        end
    end

    assign m.tdata  = r_tdata;
    assign m.tvalid = (r_state == SEND);
    assign m.tlast  = r_tlast;
    assign busy     = (r_state == SEND);
    assign done     = r_done;
    assign err      = r_err;
    assign sort_dir = r_sort_dir;

endmodule

// File: tb/tb_axis_sort_feeder.sv
// Self-checking bench for axis_sort_feeder: a shadow copy of the buffer
// predicts every beat, with directed and randomized ready patterns.
module tb_axis_sort_feeder;

    localparam int AS = 1024;
    localparam int AW = 10;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0]   wr_data = '0;
    logic          start = 1'b0;
    logic [LW-1:0] length = '0;
    logic          dir_in = 1'b0;
    logic          sort_dir, busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mdl [AS];

    axis_sort_feeder_if #(.DATA_WIDTH(32)) s_if ();

    axis_sort_feeder #(
        .DATA_WIDTH (32),
        .ELEM_WIDTH (16),
        .ARRAY_SIZE (AS)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .length   (length),
        .dir_in   (dir_in),
        .sort_dir (sort_dir),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .m        (s_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        mdl[AW'(a)] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_tvalid"}, 64'(s_if.tvalid), 64'(0));
        check({tag, "_busy"},   64'(busy),        64'(0));
        check({tag, "_done"},   64'(done),        64'(0));
    endtask

    // mode 0: ready always 1, mode 1: random ready, mode 2: ready from pat.
    // noise drives a buffer write and a fresh start every cycle of SEND.
    // abort_at >= 0 pulls reset while that beat is on the bus.
    task automatic xfer(input int len, input bit dir, input int mode,
                        input logic [31:0] pat, input bit noise, input int abort_at);
        int          n = len / 2;
        int          k = 0;
        int          c = 0;
        logic [31:0] exp;
        bit          rdy;
        start  = 1'b1;
        length = LW'(len);
        dir_in = dir;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        while (k < n && c < 4 * n + 20) begin
            exp = {mdl[AW'(2 * k + 1)], mdl[AW'(2 * k)]};
            if (k == abort_at) begin
                resetn = 1'b0;
                #1;
                check_idle_zero("abort");
                check("abort_tdata", 64'(s_if.tdata), 64'(0));
                check("abort_sortdir", 64'(sort_dir), 64'(0));
                @(negedge clk);
                resetn = 1'b1;
                s_if.tready = 1'b0;
                @(negedge clk);
                check_idle_zero("post_abort");
                return;
            end
            check("tvalid",   64'(s_if.tvalid), 64'(1));
            check("tdata",    64'(s_if.tdata),  64'(exp));
            check("tlast",    64'(s_if.tlast),  64'(k == n - 1));
            check("busy",     64'(busy),        64'(1));
            check("done_mid", 64'(done),        64'(0));
            check("err_mid",  64'(err),         64'(0));
            check("sort_dir", 64'(sort_dir),    64'(dir));
            if (noise) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = 16'hFFFF;
                start   = 1'b1;
                length  = LW'(4);
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = 1'($urandom_range(0, 1));
            else                rdy = (c < 32) ? pat[5'(c)] : 1'b1;
            s_if.tready = rdy;
            @(negedge clk);
            if (rdy) k++;
            c++;
        end
        wr_en = 1'b0;
        start = 1'b0;
        s_if.tready = 1'b0;
        check("beats",     64'(k),           64'(n));
        check("done",      64'(done),        64'(1));
        check("end_valid", 64'(s_if.tvalid), 64'(0));
        check("end_busy",  64'(busy),        64'(0));
        check("end_err",   64'(err),         64'(0));
    endtask

    initial begin
        int bad_len [3] = '{0, 3, 1026};
        s_if.tready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tvalid",  64'(s_if.tvalid), 64'(0));
        check("rst_tlast",   64'(s_if.tlast),  64'(0));
        check("rst_tdata",   64'(s_if.tdata),  64'(0));
        check("rst_busy",    64'(busy),        64'(0));
        check("rst_done",    64'(done),        64'(0));
        check("rst_err",     64'(err),         64'(0));
        check("rst_sortdir", 64'(sort_dir),    64'(0));
        resetn = 1'b1;
        @(negedge clk);

        // basic transfer
        wr(0, 16'd5); wr(1, 16'd3); wr(2, 16'd9); wr(3, 16'd1);
        xfer(4, 1'b1, 0, 32'h0, 1'b0, -1);

        // backpressure: ready 1,0,0,1,0,1,1
        wr(4, 16'h1234); wr(5, 16'hABCD);
        xfer(6, 1'b0, 2, 32'b1101001, 1'b0, -1);

        // rejected lengths
        foreach (bad_len[i]) begin
            start  = 1'b1;
            length = LW'(bad_len[i]);
            dir_in = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("rej_err",    64'(err),         64'(1));
            check("rej_tvalid", 64'(s_if.tvalid), 64'(0));
            check("rej_busy",   64'(busy),        64'(0));
            @(negedge clk);
            check("rej_err_off", 64'(err),         64'(0));
            check("rej_idle",    64'(s_if.tvalid), 64'(0));
        end

        // full buffer, then a back-to-back start in the done cycle
        for (int i = 0; i < AS; i++) wr(i, 16'(i));
        xfer(AS, 1'b1, 0, 32'h0, 1'b0, -1);
        xfer(8, 1'b0, 1, 32'h0, 1'b0, -1);

        // writes and start during SEND are ignored
        xfer(8, 1'b1, 1, 32'h0, 1'b1, -1);
        xfer(2, 1'b0, 0, 32'h0, 1'b0, -1);

        // write and start in the same cycle: write visible in beat 0
        wr_en = 1'b1; wr_addr = AW'(1); wr_data = 16'hBEEF; mdl[1] = 16'hBEEF;
        xfer(2, 1'b1, 0, 32'h0, 1'b0, -1);
        wr_en = 1'b1; wr_addr = AW'(0); wr_data = 16'h600D; mdl[0] = 16'h600D;
        xfer(4, 1'b0, 1, 32'h0, 1'b0, -1);

        // reset at beat 2 of 8, then a fresh transfer from beat 0
        for (int i = 0; i < 16; i++) wr(i, 16'($urandom));
        xfer(16, 1'b1, 0, 32'h0, 1'b0, 2);
        xfer(16, 1'b1, 0, 32'h0, 1'b0, -1);

        // randomized transfers
        for (int t = 0; t < 20; t++) begin
            for (int j = 0; j < 6; j++) wr(int'($urandom_range(0, 127)), 16'($urandom));
            xfer(2 * int'($urandom_range(1, 64)), 1'($urandom_range(0, 1)), 1, 32'h0, 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_sort_feeder.md
# axis_sort_feeder

AXI-Stream transmitter that feeds the sort engine's input stream (`ain_*`). Software or a test harness loads an array of 16-bit elements into a local buffer through a simple write port. On `start`, the block streams the array as 32-bit beats, two elements per beat, with correct `tvalid`/`tready`/`tlast` behaviour. It forms the producer end of the same stream the sort engine consumes, and it drives the `sort_dir` the engine uses for that transfer.

## Interface
- `DATA_WIDTH`, default 32: stream width. Must equal 2×`ELEM_WIDTH`.
- `ELEM_WIDTH`, default 16: element width.
- `ARRAY_SIZE`, default 1024: buffer depth in elements. Must be even and ≥ 2.
- `clk`  in  1  clock.
- `resetn`  in  1  reset: asynchronous, active-low.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  $clog2(ARRAY_SIZE)  element index.
- `wr_data`  in  ELEM_WIDTH  element value.
- `start`  in  1  start-transfer pulse.
- `length`  in  $clog2(ARRAY_SIZE)+1  element count, sampled with `start`.
- `dir_in`  in  1  sort direction (1 = ascending), sampled with `start`.
- `sort_dir`  out  1  latched direction, held for the whole transfer.
- `busy`  out  1  high from the cycle after an accepted `start` until the last handshake.
- `done`  out  1  one-cycle pulse, the cycle after the last handshake.
- `err`  out  1  one-cycle pulse when `start` is rejected.
- `m_tdata`  out  DATA_WIDTH  stream data; `[15:0]` = element 2k, `[31:16]` = element 2k+1.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  stream ready.
- `m_tlast`  out  1  asserted on the final beat.

## Operation
- FSM states: IDLE, SEND.
- **Buffer writes**
  - Accepted only in IDLE. A write lands in the element at `wr_addr`.
  - `wr_en` in SEND is discarded, so buffer contents stay stable during a transfer.
  - Buffer contents are not reset.
- **IDLE → SEND** on `start` when `length` is even, nonzero and ≤ `ARRAY_SIZE`. On that edge the block latches:
  - `beats_q = length/2`
  - `sort_dir = dir_in`
  - `beat_idx = 0`
- **Rejected start.** `start` with an invalid `length` raises `err` for one cycle and the FSM stays in IDLE.
- **SEND**
  - `m_tvalid` = 1 and `m_tdata` = {buf[2·beat_idx+1], buf[2·beat_idx]}.
  - `m_tlast` = (`beat_idx == beats_q-1`).
  - On a handshake (`m_tvalid && m_tready`) that is not the last beat: `beat_idx++`, and `tdata`/`tlast` load the next beat on the same edge.
  - On the last-beat handshake: go to IDLE, `m_tvalid` = 0 next cycle, `done` pulses.
- `start` in SEND is ignored: no `err`, no restart.
- Arithmetic: `beat_idx` is $clog2(ARRAY_SIZE) bits wide and never wraps, because it is bounded by `beats_q-1`.

## Timing
- **Reset values:**
  - `m_tvalid` = 0, `m_tlast` = 0, `m_tdata` = 0
  - `busy` = 0, `done` = 0, `err` = 0, `sort_dir` = 0
  - FSM in IDLE
- **Start latency:** `start` sampled at edge N gives `m_tvalid` = 1 and beat 0 on the outputs after edge N, i.e. visible in cycle N+1.
- **Throughput:** one beat per cycle while `m_tready` = 1. A transfer of L elements under constant ready takes L/2 cycles in SEND.
- **Stability:** all stream outputs are registered. Once `m_tvalid` is high, `m_tdata` and `m_tlast` hold until a handshake. `m_tvalid` never drops without a handshake.
- **No ready dependence:** `m_tvalid` does not depend on `m_tready` combinationally.
- **`done` timing:** `done` is asserted in the cycle after the last handshake, the same cycle in which `m_tvalid` and `busy` are 0.
- **Back-to-back:** a `start` in the `done` cycle is accepted, giving one idle cycle between transfers.
- **Reset mid-transfer:** asynchronous return to the reset values. The remaining beats are abandoned and there is no `done`.
- **Write/start same cycle:** if `wr_en` and an accepted `start` arrive in the same IDLE cycle, the write commits first and is visible in the transfer.

## Structure
- Shared package `axis_sort_pkg` holds:
  - `ELEM_W` = 16
  - the state enum `feeder_state_t` {IDLE, SEND}
  - the length-validity function, which the sort engine's input side reuses
- Sub-module `axis_sort_feeder_buf`:
  - ARRAY_SIZE × ELEM_WIDTH register array
  - one write port
  - one paired read port that returns elements 2k and 2k+1 for beat address k, used for next-beat lookahead

## Test plan
- **Basic transfer:** load elements 0..3 = 5, 3, 9, 1; `start` with `length` = 4 and `dir_in` = 1; ready held at 1. Expect beat 0 = 0x0003_0005 (`tlast` = 0), then beat 1 = 0x0001_0009 (`tlast` = 1), `done` one cycle later, and `sort_dir` = 1 throughout.
- **Backpressure:** `length` = 6, `m_tready` toggling 1,0,0,1,0,1,1. Expect `tdata`/`tlast` stable across every stall, exactly 3 handshakes, and `tlast` only on the third.
- **Rejected lengths:** `start` with `length` = 0, 3 and 1026 (ARRAY_SIZE = 1024). Expect three `err` pulses, `m_tvalid` staying at 0, and `busy` staying at 0.
- **Full buffer:** `length` = 1024 with buf[i] = i. Expect 512 beats, the final beat = 0x03FF_03FE with `tlast` = 1, and no wrap.
- **Busy-time inputs:** `wr_en` to address 0 with value 0xFFFF, plus a second `start`, both during SEND. Expect the current transfer unaffected and buf[0] unchanged after `done`.
- **Reset mid-transfer:** assert `resetn` = 0 at beat 2 of 8. Expect `m_tvalid`, `busy` and `done` all 0 immediately. A new `start` after release must send from beat 0.
